// File: rtl/v_encoder.sv
// v_encoder: turns decoded vector micro-op requests into RVV 1.0 words.
// Legal requests are encoded at the input and buffered in a DEPTH-entry FIFO.
// Illegal requests are dropped and flagged with a one-cycle enc_err pulse.
// Words leave through a single output register with a valid/ready handshake.
// Optional feature macro: V_ENC_AUTO_VSET_EN. When it is defined, the encoder
// tracks the current SEW and emits "vsetvli x0,x0,<sew>" ahead of any op
// whose SEW differs from the last one programmed. When it is undefined,
// req_sew is ignored and each request produces exactly one word.
//
// Op codes (req_op) per unit:
//   ALU : 1 ADD, 2 SUB, 3 RSUB, 4 AND, 5 OR, 6 XOR, 7 SLL, 8 SRL, 9 SRA,
//         10 MINU, 11 MIN, 12 MAXU, 13 MAX
//   MUL : op ignored (vmul)
//   RED : 1 SUM, 2 AND, 3 OR, 4 XOR, 5 MINU, 6 MIN, 7 MAXU, 8 MAX
//   SLDU: 1 SLIDEUP, 2 SLIDEDOWN, 3 SLIDE1UP, 4 SLIDE1DOWN, 5 RGATHER
//   LSU : 1-3 VLE8/16/32, 4-6 VLSE8/16/32, 7-9 VSE8/16/32, 10-12 VSSE8/16/32
module v_encoder #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_unit,
    input  logic [3:0]  req_op,
    input  logic [1:0]  req_src,
    input  logic [4:0]  req_vd,
    input  logic [4:0]  req_a,
    input  logic [4:0]  req_b,
    input  logic [1:0]  req_sew,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        enc_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    localparam logic [6:0] OPC_RTYPE = 7'b1010111;
    localparam logic [6:0] OPC_LTYPE = 7'b0000111;
    localparam logic [6:0] OPC_STYPE = 7'b0100111;

    localparam logic [2:0] OPI_VV = 3'b000;
    localparam logic [2:0] OPI_VX = 3'b100;
    localparam logic [2:0] OPI_VI = 3'b011;
    localparam logic [2:0] OPM_VV = 3'b010;
    localparam logic [2:0] OPM_VX = 3'b110;

    localparam logic [1:0] MOP_UNIT_STRIDE = 2'b00;
    localparam logic [1:0] MOP_STRIDED     = 2'b10;

    localparam logic [2:0] WIDTH_8  = 3'b000;
    localparam logic [2:0] WIDTH_16 = 3'b101;
    localparam logic [2:0] WIDTH_32 = 3'b110;

    localparam logic [1:0] SRC_VV = 2'b01;
    localparam logic [1:0] SRC_VX = 2'b10;
    localparam logic [1:0] SRC_VI = 2'b11;

    localparam logic [2:0] UNIT_ALU  = 3'd0;
    localparam logic [2:0] UNIT_MUL  = 3'd1;
    localparam logic [2:0] UNIT_RED  = 3'd2;
    localparam logic [2:0] UNIT_SLDU = 3'd3;
    localparam logic [2:0] UNIT_LSU  = 3'd4;

    localparam logic [3:0] VALU_ADD  = 4'd1;
    localparam logic [3:0] VALU_SUB  = 4'd2;
    localparam logic [3:0] VALU_RSUB = 4'd3;
    localparam logic [3:0] VALU_AND  = 4'd4;
    localparam logic [3:0] VALU_OR   = 4'd5;
    localparam logic [3:0] VALU_XOR  = 4'd6;
    localparam logic [3:0] VALU_SLL  = 4'd7;
    localparam logic [3:0] VALU_SRL  = 4'd8;
    localparam logic [3:0] VALU_SRA  = 4'd9;
    localparam logic [3:0] VALU_MINU = 4'd10;
    localparam logic [3:0] VALU_MIN  = 4'd11;
    localparam logic [3:0] VALU_MAXU = 4'd12;
    localparam logic [3:0] VALU_MAX  = 4'd13;

    localparam logic [3:0] VRED_SUM  = 4'd1;
    localparam logic [3:0] VRED_AND  = 4'd2;
    localparam logic [3:0] VRED_OR   = 4'd3;
    localparam logic [3:0] VRED_XOR  = 4'd4;
    localparam logic [3:0] VRED_MINU = 4'd5;
    localparam logic [3:0] VRED_MIN  = 4'd6;
    localparam logic [3:0] VRED_MAXU = 4'd7;
    localparam logic [3:0] VRED_MAX  = 4'd8;

    localparam logic [3:0] VSLDU_SLIDEUP    = 4'd1;
    localparam logic [3:0] VSLDU_SLIDEDOWN  = 4'd2;
    localparam logic [3:0] VSLDU_SLIDE1UP   = 4'd3;
    localparam logic [3:0] VSLDU_SLIDE1DOWN = 4'd4;
    localparam logic [3:0] VSLDU_RGATHER    = 4'd5;

    localparam logic [3:0] VLSU_VLE8   = 4'd1;
    localparam logic [3:0] VLSU_VLE16  = 4'd2;
    localparam logic [3:0] VLSU_VLE32  = 4'd3;
    localparam logic [3:0] VLSU_VLSE8  = 4'd4;
    localparam logic [3:0] VLSU_VLSE16 = 4'd5;
    localparam logic [3:0] VLSU_VLSE32 = 4'd6;
    localparam logic [3:0] VLSU_VSE8   = 4'd7;
    localparam logic [3:0] VLSU_VSE16  = 4'd8;
    localparam logic [3:0] VLSU_VSE32  = 4'd9;
    localparam logic [3:0] VLSU_VSSE8  = 4'd10;
    localparam logic [3:0] VLSU_VSSE16 = 4'd11;
    localparam logic [3:0] VLSU_VSSE32 = 4'd12;

    // Per-request decode results. src_mask bit0 = VV allowed, bit1 = VX, bit2 = VI.
    logic [5:0]  funct6;
    logic [2:0]  funct3;
    logic [2:0]  src_mask;
    logic        use_opm;
    logic        slide1;
    logic        op_known;
    logic        src_ok;
    logic        sew_ok;
    logic        lsu_store;
    logic        lsu_strided;
    logic [2:0]  lsu_width;
    logic        enc_legal;
    logic [31:0] enc_word;

    // FIFO and output-side control.
    logic [31:0]    fifo_word [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0] count;
    logic           push;
    logic           pop;
    logic           load;
    logic [31:0]    load_word;
    logic [31:0]    head_word;
    logic           slot_free;
    logic           fifo_empty;

    // Look up funct6, permitted operand sources and LSU fields for the request.
    always_comb begin
        funct6      = 6'b000000;
        src_mask    = 3'b000;
        use_opm     = 1'b0;
        slide1      = 1'b0;
        op_known    = 1'b1;
        lsu_store   = 1'b0;
        lsu_strided = 1'b0;
        lsu_width   = WIDTH_8;
        case (req_unit)
            UNIT_ALU: begin
                case (req_op)
                    VALU_ADD:  begin funct6 = 6'b000000; src_mask = 3'b111; end
                    VALU_SUB:  begin funct6 = 6'b000010; src_mask = 3'b011; end
                    VALU_RSUB: begin funct6 = 6'b000011; src_mask = 3'b110; end
                    VALU_AND:  begin funct6 = 6'b001001; src_mask = 3'b111; end
                    VALU_OR:   begin funct6 = 6'b001010; src_mask = 3'b111; end
                    VALU_XOR:  begin funct6 = 6'b001011; src_mask = 3'b111; end
                    VALU_SLL:  begin funct6 = 6'b100101; src_mask = 3'b111; end
                    VALU_SRL:  begin funct6 = 6'b101000; src_mask = 3'b111; end
                    VALU_SRA:  begin funct6 = 6'b101001; src_mask = 3'b111; end
                    VALU_MINU: begin funct6 = 6'b000100; src_mask = 3'b011; end
                    VALU_MIN:  begin funct6 = 6'b000101; src_mask = 3'b011; end
                    VALU_MAXU: begin funct6 = 6'b000110; src_mask = 3'b011; end
                    VALU_MAX:  begin funct6 = 6'b000111; src_mask = 3'b011; end
                    default:   op_known = 1'b0;
                endcase
            end
            UNIT_MUL: begin
                funct6   = 6'b100101;
                src_mask = 3'b011;
                use_opm  = 1'b1;
            end
            UNIT_RED: begin
                src_mask = 3'b001;
                use_opm  = 1'b1;
                case (req_op)
                    VRED_SUM:  funct6 = 6'b000000;
                    VRED_AND:  funct6 = 6'b000001;
                    VRED_OR:   funct6 = 6'b000010;
                    VRED_XOR:  funct6 = 6'b000011;
                    VRED_MINU: funct6 = 6'b000100;
                    VRED_MIN:  funct6 = 6'b000101;
                    VRED_MAXU: funct6 = 6'b000110;
                    VRED_MAX:  funct6 = 6'b000111;
                    default:   op_known = 1'b0;
                endcase
            end
            UNIT_SLDU: begin
                case (req_op)
                    VSLDU_SLIDEUP:    begin funct6 = 6'b001110; src_mask = 3'b110; end
                    VSLDU_SLIDEDOWN:  begin funct6 = 6'b001111; src_mask = 3'b110; end
                    VSLDU_SLIDE1UP:   begin funct6 = 6'b001110; src_mask = 3'b010; slide1 = 1'b1; end
                    VSLDU_SLIDE1DOWN: begin funct6 = 6'b001111; src_mask = 3'b010; slide1 = 1'b1; end
                    VSLDU_RGATHER:    begin funct6 = 6'b001100; src_mask = 3'b111; end
                    default:          op_known = 1'b0;
                endcase
            end
            UNIT_LSU: begin
                src_mask = 3'b111;
                case (req_op)
                    VLSU_VLE8:   lsu_width = WIDTH_8;
                    VLSU_VLE16:  lsu_width = WIDTH_16;
                    VLSU_VLE32:  lsu_width = WIDTH_32;
                    VLSU_VLSE8:  begin lsu_strided = 1'b1; lsu_width = WIDTH_8;  end
                    VLSU_VLSE16: begin lsu_strided = 1'b1; lsu_width = WIDTH_16; end
                    VLSU_VLSE32: begin lsu_strided = 1'b1; lsu_width = WIDTH_32; end
                    VLSU_VSE8:   begin lsu_store = 1'b1; lsu_width = WIDTH_8;  end
                    VLSU_VSE16:  begin lsu_store = 1'b1; lsu_width = WIDTH_16; end
                    VLSU_VSE32:  begin lsu_store = 1'b1; lsu_width = WIDTH_32; end
                    VLSU_VSSE8:  begin lsu_store = 1'b1; lsu_strided = 1'b1; lsu_width = WIDTH_8;  end
                    VLSU_VSSE16: begin lsu_store = 1'b1; lsu_strided = 1'b1; lsu_width = WIDTH_16; end
                    VLSU_VSSE32: begin lsu_store = 1'b1; lsu_strided = 1'b1; lsu_width = WIDTH_32; end
                    default:     op_known = 1'b0;
                endcase
            end
            default: op_known = 1'b0;
        endcase
    end

    // Pick funct3 from the operand source, judge legality and build the word.
    always_comb begin
        src_ok = 1'b0;
        funct3 = OPI_VV;
        case (req_src)
            SRC_VV: begin src_ok = src_mask[0]; funct3 = use_opm ? OPM_VV : OPI_VV; end
            SRC_VX: begin src_ok = src_mask[1]; funct3 = use_opm ? OPM_VX : OPI_VX; end
            SRC_VI: begin src_ok = src_mask[2]; funct3 = OPI_VI; end
            default: src_ok = 1'b0;
        endcase
        if (slide1) begin
            funct3 = OPM_VX;
        end
`ifdef V_ENC_AUTO_VSET_EN
        sew_ok = (req_sew != 2'd3);
`else
        sew_ok = 1'b1;
`endif
        enc_legal = op_known && src_ok && sew_ok;
        if (req_unit == UNIT_LSU) begin
            enc_word = {3'b000, 1'b0,
                        lsu_strided ? MOP_STRIDED : MOP_UNIT_STRIDE, 1'b1,
                        lsu_strided ? req_b : 5'd0,
                        req_a, lsu_width, req_vd,
                        lsu_store ? OPC_STYPE : OPC_LTYPE};
        end else begin
            enc_word = {funct6, 1'b1, req_b, req_a, funct3, req_vd, OPC_RTYPE};
        end
    end

    assign req_ready  = (count != FULL_COUNT);
    assign fifo_empty = (count == '0);
    assign slot_free  = !instr_valid || instr_ready;
    assign push       = req_valid && req_ready && enc_legal && !flush;
    assign head_word  = fifo_word[rd_ptr];

`ifdef V_ENC_AUTO_VSET_EN
    typedef enum logic {RUN, VSET} state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  fifo_sew [DEPTH];
    logic [1:0]  head_sew;
    logic [1:0]  cur_sew;
    logic        cur_sew_valid;
    logic        set_sew;
    logic [31:0] vset_word;

    assign head_sew  = fifo_sew[rd_ptr];
    assign vset_word = {1'b0, 3'b000, 1'b0, 1'b0, 1'b0, head_sew, 3'b000,
                        5'd0, 3'b111, 5'd0, OPC_RTYPE};

    // Store the encoded word and its SEW together so the vset decision is made at the head.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_word[wr_ptr] <= enc_word;
            fifo_sew[wr_ptr]  <= req_sew;
        end
    end

    // State register; flush always returns to RUN.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= RUN;
        end else if (flush) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Remember the SEW last programmed; invalid forces a vset on the next op.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cur_sew       <= 2'd0;
            cur_sew_valid <= 1'b0;
        end else if (flush) begin
            cur_sew       <= 2'd0;
            cur_sew_valid <= 1'b0;
        end else if (set_sew) begin
            cur_sew       <= head_sew;
            cur_sew_valid <= 1'b1;
        end
    end

    // Decide each free output slot: a vset (head stays put) or the head op (popped).
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_word  = head_word;
        pop        = 1'b0;
        set_sew    = 1'b0;
        case (state)
            RUN: begin
                if (slot_free && !fifo_empty) begin
                    load = 1'b1;
                    if (!cur_sew_valid || (head_sew != cur_sew)) begin
                        load_word  = vset_word;
                        set_sew    = 1'b1;
                        state_next = VSET;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            VSET: begin
                if (slot_free) begin
                    load       = 1'b1;
                    pop        = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end
`else
    logic unused_sew;
    assign unused_sew = ^req_sew;

    // Store the encoded word; SEW plays no part in this build.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_word[wr_ptr] <= enc_word;
        end
    end

    // Every free output slot takes the head op directly.
    always_comb begin
        load      = slot_free && !fifo_empty;
        pop       = load;
        load_word = head_word;
    end
`endif

    // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output register: holds its word until the consumer takes it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            instr       <= '0;
            instr_valid <= 1'b0;
        end else if (flush) begin
            instr       <= '0;
            instr_valid <= 1'b0;
        end else if (load) begin
            instr       <= load_word;
            instr_valid <= 1'b1;
        end else if (instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

    // One-cycle error pulse for an accepted but illegal request; flush suppresses it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            enc_err <= 1'b0;
        end else begin
            enc_err <= req_valid && req_ready && !enc_legal && !flush;
        end
    end

endmodule

// File: tb/tb_v_encoder.sv
// Testbench for v_encoder: directed scenarios followed by randomized traffic,
// all checked against a table-driven reference encoder and a word scoreboard.
module tb_v_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        nrst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_unit;
    logic [3:0]  req_op;
    logic [1:0]  req_src;
    logic [4:0]  req_vd;
    logic [4:0]  req_a;
    logic [4:0]  req_b;
    logic [1:0]  req_sew;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        enc_err;

    always #5 clk = ~clk;

    v_encoder #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_unit    (req_unit),
        .req_op      (req_op),
        .req_src     (req_src),
        .req_vd      (req_vd),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_sew     (req_sew),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .enc_err     (enc_err)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] seen_q[$];
    bit model_sew_valid = 1'b0;
    int model_sew = 0;
    bit exp_err = 1'b0;
    int accept_count = 0;

    // Reference tables: funct6 and allowed-source set (1=VV, 2=VX, 4=VI) per op.
    int alu_f6[16];
    int alu_src[16];
    int sldu_f6[16];
    int sldu_src[16];
    bit sldu_opm[16];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    task automatic modelEncode(input int unit, input int op, input int src, input int vd,
                               input int a, input int b, input int sew,
                               output bit ok, output logic [31:0] word);
        int f6, allowed, f3, k, width;
        bit opm, force_vx, known, store, strided;
        ok = 1'b0; word = '0; f6 = 0; allowed = 0; f3 = 0; opm = 0; force_vx = 0; known = 0;
        case (unit)
            0: if (alu_src[op] != 0) begin known = 1; f6 = alu_f6[op]; allowed = alu_src[op]; end
            1: begin known = 1; f6 = 37; allowed = 3; opm = 1; end
            2: if (op >= 1 && op <= 8) begin known = 1; f6 = op - 1; allowed = 1; opm = 1; end
            3: if (sldu_src[op] != 0) begin
                   known = 1; f6 = sldu_f6[op]; allowed = sldu_src[op]; force_vx = sldu_opm[op];
               end
            4: if (op >= 1 && op <= 12) begin known = 1; allowed = 7; end
            default: known = 0;
        endcase
        if (!known || src == 0 || ((allowed >> (src - 1)) & 1) == 0) return;
`ifdef V_ENC_AUTO_VSET_EN
        if (sew == 3) return;
`endif
        ok = 1'b1;
        if (unit == 4) begin
            store   = (op > 6);
            k       = (op - 1) % 6;
            strided = (k >= 3);
            width   = ((k % 3) == 0) ? 0 : ((k % 3) == 1) ? 5 : 6;
            word = (32'd1 << 25) | (32'(a) << 15) | (32'(width) << 12) | (32'(vd) << 7)
                 | (store ? 32'd39 : 32'd7);
            if (strided) word = word | (32'd2 << 26) | (32'(b) << 20);
        end else begin
            if (force_vx)     f3 = 6;
            else if (opm)     f3 = (src == 1) ? 2 : 6;
            else              f3 = (src == 1) ? 0 : (src == 2) ? 4 : 3;
            word = (32'(f6) << 26) | (32'd1 << 25) | (32'(b) << 20) | (32'(a) << 15)
                 | (32'(f3) << 12) | (32'(vd) << 7) | 32'd87;
        end
    endtask

    // One clock: check outputs, drive inputs, update the model for this edge's handshakes.
    task automatic applyStimulus(input bit v, input int unit, input int op, input int src,
                                 input int vd, input int a, input int b, input int sew,
                                 input bit rdy, input bit fl);
        bit ok, next_err;
        logic [31:0] w, junk;
        if (instr_valid) begin
            if (exp_q.size() > 0) checkOutput("instr", instr, exp_q[0]);
            else checkOutput("spurious_valid", 32'(instr_valid), 32'd0);
        end
        checkOutput("enc_err", 32'(enc_err), 32'(exp_err));
        req_valid   = v;
        req_unit    = unit[2:0];
        req_op      = op[3:0];
        req_src     = src[1:0];
        req_vd      = vd[4:0];
        req_a       = a[4:0];
        req_b       = b[4:0];
        req_sew     = sew[1:0];
        instr_ready = rdy;
        flush       = fl;
        #1;
        next_err = 1'b0;
        if (fl) begin
            exp_q.delete();
            model_sew_valid = 1'b0;
        end else begin
            if (instr_valid && instr_ready) begin
                seen_q.push_back(instr);
                if (exp_q.size() > 0) junk = exp_q.pop_front();
            end
            if (req_valid && req_ready) begin
                accept_count++;
                modelEncode(unit, op, src, vd, a, b, sew, ok, w);
                if (ok) begin
`ifdef V_ENC_AUTO_VSET_EN
                    if (!model_sew_valid || model_sew != sew) begin
                        exp_q.push_back(32'h0000_7057 | (32'(sew) << 23));
                        model_sew = sew;
                        model_sew_valid = 1'b1;
                    end
`endif
                    exp_q.push_back(w);
                end else begin
                    next_err = 1'b1;
                end
            end
        end
        exp_err = next_err;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic doReset();
        nrst = 1'b0; req_valid = 1'b0; flush = 1'b0; instr_ready = 1'b0;
        exp_q.delete();
        model_sew_valid = 1'b0;
        exp_err = 1'b0;
        #1;
        checkOutput("rst_instr", instr, 32'd0);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_err", 32'(enc_err), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int base, fill_exp, unit, op, src, sew_r;
        bit v, rdy, fl;
        for (int i = 0; i < 16; i++) begin
            alu_f6[i] = 0; alu_src[i] = 0; sldu_f6[i] = 0; sldu_src[i] = 0; sldu_opm[i] = 0;
        end
        alu_f6[1] = 0;   alu_src[1] = 7;   alu_f6[2] = 2;   alu_src[2] = 3;
        alu_f6[3] = 3;   alu_src[3] = 6;   alu_f6[4] = 9;   alu_src[4] = 7;
        alu_f6[5] = 10;  alu_src[5] = 7;   alu_f6[6] = 11;  alu_src[6] = 7;
        alu_f6[7] = 37;  alu_src[7] = 7;   alu_f6[8] = 40;  alu_src[8] = 7;
        alu_f6[9] = 41;  alu_src[9] = 7;   alu_f6[10] = 4;  alu_src[10] = 3;
        alu_f6[11] = 5;  alu_src[11] = 3;  alu_f6[12] = 6;  alu_src[12] = 3;
        alu_f6[13] = 7;  alu_src[13] = 3;
        sldu_f6[1] = 14; sldu_src[1] = 6;  sldu_f6[2] = 15; sldu_src[2] = 6;
        sldu_f6[3] = 14; sldu_src[3] = 2;  sldu_opm[3] = 1;
        sldu_f6[4] = 15; sldu_src[4] = 2;  sldu_opm[4] = 1;
        sldu_f6[5] = 12; sldu_src[5] = 7;

        nrst = 1'b0; flush = 1'b0; req_valid = 1'b0; req_unit = '0; req_op = '0;
        req_src = '0; req_vd = '0; req_a = '0; req_b = '0; req_sew = '0; instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_instr", instr, 32'd0);
        checkOutput("reset_valid", 32'(instr_valid), 32'd0);
        checkOutput("reset_err", 32'(enc_err), 32'd0);
        checkOutput("reset_ready", 32'(req_ready), 32'd1);
        nrst = 1'b1;
        @(negedge clk);

        $display("[TB] vadd.vv after reset");
        seen_q.delete();
        applyStimulus(1, 0, 1, 1, 3, 1, 2, 2, 1, 0);
        idle(8);
`ifdef V_ENC_AUTO_VSET_EN
        checkOutput("t1_count", 32'(seen_q.size()), 32'd2);
        checkOutput("t1_vset", seen_q[0], 32'h0100_7057);
        checkOutput("t1_op", seen_q[1], 32'h0220_81D7);
`else
        checkOutput("t1_count", 32'(seen_q.size()), 32'd1);
        checkOutput("t1_op", seen_q[0], 32'h0220_81D7);
`endif

        $display("[TB] vle32 with unchanged SEW");
        seen_q.delete();
        applyStimulus(1, 4, 3, 1, 4, 10, 0, 2, 1, 0);
        idle(8);
        checkOutput("t2_count", 32'(seen_q.size()), 32'd1);
        checkOutput("t2_op", seen_q[0], 32'h0205_6207);

        $display("[TB] illegal unit");
        seen_q.delete();
        applyStimulus(1, 6, 1, 1, 1, 1, 1, 2, 1, 0);
        checkOutput("err_pulse", 32'(enc_err), 32'd1);
        idle(1);
        checkOutput("err_clear", 32'(enc_err), 32'd0);
        idle(6);
        checkOutput("err_no_word", 32'(seen_q.size()), 32'd0);
        checkOutput("err_ready", 32'(req_ready), 32'd1);

        $display("[TB] e8 then e16");
        seen_q.delete();
        applyStimulus(1, 0, 1, 1, 5, 1, 2, 0, 1, 0);
        applyStimulus(1, 0, 1, 1, 6, 1, 2, 1, 1, 0);
        idle(10);
`ifdef V_ENC_AUTO_VSET_EN
        checkOutput("t5_count", 32'(seen_q.size()), 32'd4);
        checkOutput("t5_vset8", seen_q[0], 32'h0000_7057);
        checkOutput("t5_vset16", seen_q[2], 32'h0080_7057);
`else
        checkOutput("t5_count", 32'(seen_q.size()), 32'd2);
`endif

        $display("[TB] fill FIFO with consumer stalled");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        seen_q.delete();
        base = accept_count;
`ifdef V_ENC_AUTO_VSET_EN
        fill_exp = DEPTH;
`else
        fill_exp = DEPTH + 1;
`endif
        for (int i = 0; i < 12; i++) applyStimulus(1, 0, 1, 1, accept_count - base, 1, 2, 2, 0, 0);
        checkOutput("fill_accepted", 32'(accept_count - base), 32'(fill_exp));
        checkOutput("fill_ready", 32'(req_ready), 32'd0);
        idle(12);
        checkOutput("fill_words", 32'(seen_q.size()), 32'd5);

        $display("[TB] flush with pending entries");
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 2, 7 + i, 3, 4, 2, 0, 0);
        checkOutput("pre_flush_valid", 32'(instr_valid), 32'd1);
        applyStimulus(1, 0, 1, 1, 9, 1, 2, 1, 0, 1);
        checkOutput("flush_valid", 32'(instr_valid), 32'd0);
        checkOutput("flush_ready", 32'(req_ready), 32'd1);
        seen_q.delete();
        applyStimulus(1, 0, 1, 1, 3, 1, 2, 2, 1, 0);
        idle(6);
`ifdef V_ENC_AUTO_VSET_EN
        checkOutput("post_flush_vset", seen_q[0], 32'h0100_7057);
        checkOutput("post_flush_count", 32'(seen_q.size()), 32'd2);
`else
        checkOutput("post_flush_count", 32'(seen_q.size()), 32'd1);
`endif

        $display("[TB] reset mid-transfer");
        for (int i = 0; i < 3; i++) applyStimulus(1, 2, 1 + i, 1, i, 5, 6, 1, 0, 0);
        doReset();

        $display("[TB] random traffic");
        sew_r = 2;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc == 750) doReset();
            v    = ($urandom_range(0, 2) != 0);
            unit = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
            op   = $urandom_range(0, 13);
            src  = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) sew_r = $urandom_range(0, 3);
            rdy  = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 59) == 0);
            if (fl) rdy = 1'b0;
            applyStimulus(v, unit, op, src, $urandom_range(0, 31), $urandom_range(0, 31),
                          $urandom_range(0, 31), sew_r, rdy, fl);
        end
        idle(20);
        checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("drain_valid", 32'(instr_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
